// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, STOP_BITS stop bits, BIT_TIME clocks per bit.
module uart_tx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int BIT_TIME  = 1300,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tdre,
    output logic                 tx_done,
    output logic                 TxD
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be 5..9");
        end
        if (BIT_TIME < 2) begin : g_bad_bit_time
            $error("uart_tx_cfg: BIT_TIME must be at least 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    // The guard only matters for illegal BIT_TIME, which elaboration rejects anyway.
    localparam int BAUD_W = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_TIME - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_reg;
    logic [BAUD_W-1:0]      baud_reg;
    logic [BIT_W-1:0]       bit_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_reg;
    logic                   txd_reg;
    logic                   tdre_reg;
    logic                   done_reg;
    logic                   bit_end;

    assign bit_end = (baud_reg == BAUD_LAST);

    // TxD is registered and loaded with the level of the bit being entered,
    // so the line changes exactly on the state transition edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg  <= ST_IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            txd_reg    <= 1'b1;
            tdre_reg   <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    baud_reg <= '0;
                    bit_reg  <= '0;
                    if (tx_valid) begin
                        shift_reg  <= tx_data;
                        parity_reg <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                        state_reg  <= ST_START;
                        txd_reg    <= 1'b0;
                        tdre_reg   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_reg  <= '0;
                        state_reg <= ST_DATA;
                        txd_reg   <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_reg <= '0;
                        if (bit_reg == DATA_LAST) begin
                            bit_reg <= '0;
                            if (PARITY != 0) begin
                                state_reg <= ST_PARITY;
                                txd_reg   <= parity_reg;
                            end else begin
                                state_reg <= ST_STOP;
                                txd_reg   <= 1'b1;
                            end
                        end else begin
                            bit_reg   <= bit_reg + 1'b1;
                            txd_reg   <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_reg  <= '0;
                        state_reg <= ST_STOP;
                        txd_reg   <= 1'b1;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_reg <= '0;
                        if (bit_reg == STOP_LAST) begin
                            bit_reg   <= '0;
                            state_reg <= ST_IDLE;
                            tdre_reg  <= 1'b1;
                            done_reg  <= 1'b1;
                        end else begin
                            bit_reg <= bit_reg + 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    baud_reg  <= '0;
                    bit_reg   <= '0;
                    txd_reg   <= 1'b1;
                    tdre_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign tdre    = tdre_reg;
    assign tx_done = done_reg;
    assign TxD     = txd_reg;

endmodule
